// File: rtl/axi_burst_master.sv
// axi_burst_master
// Single-request AXI4 master: INCR read bursts of 1..2^LEN_W beats or a
// single-beat strobed write. Read beats are streamed back one cycle after
// the R handshake; completion and accumulated RRESP/BRESP errors are
// reported with a one-cycle done pulse that overlaps the return to idle so
// back-to-back requests need no bubble.
module axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    // read beat stream and completion
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  err,

    // AXI read address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [7:0]            ARLEN,

    // AXI read data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,

    // AXI write address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,

    // AXI write data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,

    // AXI write response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t             state_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   count_r;
    logic               err_acc_r;

    logic               beat_fire_s;
    logic               beat_is_last_s;
    logic               beat_err_s;
    logic               aw_fire_s;
    logic               w_fire_s;
    logic               aw_complete_s;
    logic               w_complete_s;
    logic               b_fire_s;

    // Any response other than OKAY counts as a transaction error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // Decode handshakes and the per-beat error condition for the current cycle.
    always_comb begin
        beat_fire_s    = RREADY & RVALID;
        beat_is_last_s = (count_r == len_r);
        // A slave RLAST that disagrees with our own beat count is a protocol error.
        beat_err_s     = resp_is_err(RRESP) | (RLAST != beat_is_last_s);
        aw_fire_s      = AWVALID & AWREADY;
        w_fire_s       = WVALID & WREADY;
        // A channel is finished once its valid has already dropped or it handshakes now.
        aw_complete_s  = ~AWVALID | AWREADY;
        w_complete_s   = ~WVALID | WREADY;
        b_fire_s       = BREADY & BVALID;
    end

    // Main controller: state, AXI channel drivers, beat counter, and pulse outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r   <= IDLE;
            len_r     <= {LEN_W{1'b0}};
            count_r   <= {LEN_W{1'b0}};
            err_acc_r <= 1'b0;
            req_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= {DATA_W{1'b0}};
            rd_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ARVALID   <= 1'b0;
            ARADDR    <= {ADDR_W{1'b0}};
            ARLEN     <= 8'd0;
            RREADY    <= 1'b0;
            AWVALID   <= 1'b0;
            AWADDR    <= {ADDR_W{1'b0}};
            WVALID    <= 1'b0;
            WDATA     <= {DATA_W{1'b0}};
            WSTRB     <= {STRB_W{1'b0}};
            BREADY    <= 1'b0;
        end else begin
            // Pulse outputs are low unless a state below raises them.
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        count_r   <= {LEN_W{1'b0}};
                        err_acc_r <= 1'b0;
                        if (req_write) begin
                            AWADDR  <= req_addr;
                            WDATA   <= req_wdata;
                            WSTRB   <= req_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state_r <= WR_ADDR;
                        end else begin
                            len_r   <= req_len;
                            ARADDR  <= req_addr;
                            ARLEN   <= 8'(req_len);
                            ARVALID <= 1'b1;
                            state_r <= RD_ADDR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                RD_ADDR: begin
                    // Address and length are held until the slave takes them.
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state_r <= RD_DATA;
                    end else begin
                        ARVALID <= 1'b1;
                    end
                end

                RD_DATA: begin
                    if (beat_fire_s) begin
                        rd_valid <= 1'b1;
                        rd_data  <= RDATA;
                        rd_last  <= beat_is_last_s;
                        count_r  <= count_r + LEN_W'(1);
                        if (beat_is_last_s) begin
                            // Burst length is ours, not the slave's: stop on count==len.
                            RREADY    <= 1'b0;
                            done      <= 1'b1;
                            err       <= err_acc_r | beat_err_s;
                            err_acc_r <= 1'b0;
                            req_ready <= 1'b1;
                            state_r   <= IDLE;
                        end else begin
                            err_acc_r <= err_acc_r | beat_err_s;
                        end
                    end else begin
                        RREADY <= 1'b1;
                    end
                end

                WR_ADDR: begin
                    // AW and W retire independently; either may complete first.
                    if (aw_fire_s) begin
                        AWVALID <= 1'b0;
                    end else begin
                        AWVALID <= AWVALID;
                    end
                    if (w_fire_s) begin
                        WVALID <= 1'b0;
                    end else begin
                        WVALID <= WVALID;
                    end
                    if (aw_complete_s && w_complete_s) begin
                        BREADY  <= 1'b1;
                        state_r <= WR_RESP;
                    end else begin
                        BREADY  <= 1'b0;
                    end
                end

                WR_RESP: begin
                    if (b_fire_s) begin
                        BREADY    <= 1'b0;
                        done      <= 1'b1;
                        err       <= err_acc_r | resp_is_err(BRESP);
                        err_acc_r <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        BREADY <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a clean idle.
                    ARVALID   <= 1'b0;
                    RREADY    <= 1'b0;
                    AWVALID   <= 1'b0;
                    WVALID    <= 1'b0;
                    BREADY    <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master. Stimulus pushes expected AR/AW/W
// transfers, read beats and completions into queues; a monitor thread pops
// and compares whenever the DUT presents a handshake, beat or done pulse.
module tb_axi_burst_master;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        RVALID;
    logic        RREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;

    axi_burst_master #(.ADDR_W(32), .DATA_W(64), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; } w_exp_t;
    typedef struct { logic [63:0] data; logic last; } rd_exp_t;
    typedef struct { logic err; logic with_rd; } done_exp_t;

    ar_exp_t     exp_ar[$];
    logic [31:0] exp_aw[$];
    w_exp_t      exp_w[$];
    rd_exp_t     exp_rd[$];
    done_exp_t   exp_done[$];

    int vectors;
    int miscompares;

    // Free-running 100 MHz clock.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Absolute time limit so a stuck run still terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                             input logic [63:0] wdata, input logic [7:0] wstrb);
        int n;
        req_write = wr; req_addr = addr; req_len = len;
        req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk1("req_accept_wait", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ar_accept(input int dly);
        int n;
        repeat (dly) tick();
        ARREADY = 1'b1;
        n = 0;
        while (ARVALID !== 1'b1 && n < 50) begin tick(); n++; end
        chk1("ar_wait", ARVALID, 1'b1);
        tick();
        ARREADY = 1'b0;
    endtask

    task automatic rd_beat(input logic [63:0] data, input logic last, input logic [1:0] resp);
        int n;
        RDATA = data; RLAST = last; RRESP = resp; RVALID = 1'b1;
        n = 0;
        while (RREADY !== 1'b1 && n < 50) begin tick(); n++; end
        chk1("r_wait", RREADY, 1'b1);
        tick();
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    endtask

    task automatic b_resp(input logic [1:0] resp);
        int n;
        BRESP = resp; BVALID = 1'b1;
        n = 0;
        while (BREADY !== 1'b1 && n < 50) begin tick(); n++; end
        chk1("b_wait", BREADY, 1'b1);
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
    endtask

    task automatic settle_and_drain(input string tag);
        repeat (3) tick();
        chk({tag, "_ar_left"},   64'(exp_ar.size()),   64'd0);
        chk({tag, "_aw_left"},   64'(exp_aw.size()),   64'd0);
        chk({tag, "_w_left"},    64'(exp_w.size()),    64'd0);
        chk({tag, "_rd_left"},   64'(exp_rd.size()),   64'd0);
        chk({tag, "_done_left"}, 64'(exp_done.size()), 64'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        ARESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_len = 4'd0; req_wdata = 64'd0; req_wstrb = 8'd0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 64'd0; RRESP = 2'b00; RLAST = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;

        // Monitor: compare every DUT-presented event against the queues.
        fork
            forever begin
                @(negedge ACLK);
                if (ARVALID === 1'b1 && ARREADY === 1'b1) begin
                    chk1("ar_expected", exp_ar.size() != 0, 1'b1);
                    if (exp_ar.size() != 0) begin
                        ar_exp_t a;
                        a = exp_ar.pop_front();
                        chk("ARADDR", 64'(ARADDR), 64'(a.addr));
                        chk("ARLEN",  64'(ARLEN),  64'(a.len));
                    end
                end
                if (AWVALID === 1'b1 && AWREADY === 1'b1) begin
                    chk1("aw_expected", exp_aw.size() != 0, 1'b1);
                    if (exp_aw.size() != 0) chk("AWADDR", 64'(AWADDR), 64'(exp_aw.pop_front()));
                end
                if (WVALID === 1'b1 && WREADY === 1'b1) begin
                    chk1("w_expected", exp_w.size() != 0, 1'b1);
                    if (exp_w.size() != 0) begin
                        w_exp_t w;
                        w = exp_w.pop_front();
                        chk("WDATA", WDATA, w.data);
                        chk("WSTRB", 64'(WSTRB), 64'(w.strb));
                    end
                end
                if (rd_valid === 1'b1) begin
                    chk1("rd_expected", exp_rd.size() != 0, 1'b1);
                    if (exp_rd.size() != 0) begin
                        rd_exp_t r;
                        r = exp_rd.pop_front();
                        chk("rd_data", rd_data, r.data);
                        chk1("rd_last", rd_last, r.last);
                    end
                end
                if (done === 1'b1) begin
                    chk1("done_expected", exp_done.size() != 0, 1'b1);
                    if (exp_done.size() != 0) begin
                        done_exp_t d;
                        d = exp_done.pop_front();
                        chk1("done_err", err, d.err);
                        chk1("done_with_rd_valid", rd_valid, d.with_rd);
                        chk1("done_req_ready", req_ready, 1'b1);
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) tick();
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_arvalid",   ARVALID,   1'b0);
        chk1("rst_rready",    RREADY,    1'b0);
        chk1("rst_awvalid",   AWVALID,   1'b0);
        chk1("rst_wvalid",    WVALID,    1'b0);
        chk1("rst_bready",    BREADY,    1'b0);
        chk1("rst_done",      done,      1'b0);
        chk1("rst_rd_valid",  rd_valid,  1'b0);
        ARESETn = 1'b1;
        tick();

        // Single-beat read, ARREADY two cycles late.
        exp_ar.push_back('{32'h8000_0000, 8'd0});
        exp_rd.push_back('{64'h1122_3344_5566_7788, 1'b1});
        exp_done.push_back('{1'b0, 1'b1});
        issue_req(1'b0, 32'h8000_0000, 4'd0, 64'd0, 8'd0);
        chk1("rd_addr_req_ready_low", req_ready, 1'b0);
        ar_accept(2);
        rd_beat(64'h1122_3344_5566_7788, 1'b1, 2'b00);
        settle_and_drain("single_rd");

        // Four-beat burst with gaps, then a request on the done cycle.
        exp_ar.push_back('{32'h0000_1008, 8'd3});
        for (int i = 0; i < 4; i++) exp_rd.push_back('{64'hA0 + 64'(i), i == 3});
        exp_done.push_back('{1'b0, 1'b1});
        issue_req(1'b0, 32'h0000_1008, 4'd3, 64'd0, 8'd0);
        ar_accept(0);
        for (int i = 0; i < 4; i++) begin
            rd_beat(64'hA0 + 64'(i), i == 3, 2'b00);
            if (i != 3) tick();
        end
        chk1("b2b_done_cycle", done, 1'b1);
        chk1("b2b_ready_cycle", req_ready, 1'b1);
        exp_ar.push_back('{32'h0000_2003, 8'd0});
        exp_rd.push_back('{64'h55, 1'b1});
        exp_done.push_back('{1'b0, 1'b1});
        issue_req(1'b0, 32'h0000_2003, 4'd0, 64'd0, 8'd0);
        chk1("b2b_accepted_no_bubble", ARVALID, 1'b1);
        ar_accept(0);
        rd_beat(64'h55, 1'b1, 2'b00);
        settle_and_drain("burst_rd");

        // Write: AW handshakes three cycles before W.
        exp_aw.push_back(32'h8000_0010);
        exp_w.push_back('{64'hDEAD_BEEF_CAFE_F00D, 8'h0F});
        exp_done.push_back('{1'b0, 1'b0});
        issue_req(1'b1, 32'h8000_0010, 4'd7, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        chk1("aw_dropped", AWVALID, 1'b0);
        chk1("w_held", WVALID, 1'b1);
        chk1("no_bready_before_w", BREADY, 1'b0);
        tick(); tick();
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        b_resp(2'b00);
        settle_and_drain("wr_ok");

        // Write with simultaneous AW/W handshake and SLVERR response.
        exp_aw.push_back(32'h0000_0101);
        exp_w.push_back('{64'h0123_4567_89AB_CDEF, 8'hF0});
        exp_done.push_back('{1'b1, 1'b0});
        issue_req(1'b1, 32'h0000_0101, 4'd0, 64'h0123_4567_89AB_CDEF, 8'hF0);
        AWREADY = 1'b1; WREADY = 1'b1;
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
        b_resp(2'b10);
        settle_and_drain("wr_err");

        // Two-beat read with SLVERR on beat 0.
        exp_ar.push_back('{32'h0000_3000, 8'd1});
        exp_rd.push_back('{64'hB0, 1'b0});
        exp_rd.push_back('{64'hB1, 1'b1});
        exp_done.push_back('{1'b1, 1'b1});
        issue_req(1'b0, 32'h0000_3000, 4'd1, 64'd0, 8'd0);
        ar_accept(1);
        rd_beat(64'hB0, 1'b0, 2'b10);
        rd_beat(64'hB1, 1'b1, 2'b00);
        settle_and_drain("rresp_err");

        // Two-beat read where the slave raises RLAST early.
        exp_ar.push_back('{32'h0000_4000, 8'd1});
        exp_rd.push_back('{64'hC0, 1'b0});
        exp_rd.push_back('{64'hC1, 1'b1});
        exp_done.push_back('{1'b1, 1'b1});
        issue_req(1'b0, 32'h0000_4000, 4'd1, 64'd0, 8'd0);
        ar_accept(0);
        rd_beat(64'hC0, 1'b1, 2'b00);
        chk1("early_rlast_still_reading", RREADY, 1'b1);
        rd_beat(64'hC1, 1'b1, 2'b00);
        settle_and_drain("rlast_err");

        // Reset in the middle of a read burst.
        exp_ar.push_back('{32'h0000_5000, 8'd3});
        exp_rd.push_back('{64'hD0, 1'b0});
        issue_req(1'b0, 32'h0000_5000, 4'd3, 64'd0, 8'd0);
        ar_accept(0);
        rd_beat(64'hD0, 1'b0, 2'b00);
        ARESETn = 1'b0;
        tick();
        chk1("midrst_rready",    RREADY,    1'b0);
        chk1("midrst_req_ready", req_ready, 1'b1);
        chk1("midrst_done",      done,      1'b0);
        chk1("midrst_rd_valid",  rd_valid,  1'b0);
        ARESETn = 1'b1;
        settle_and_drain("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
Parametrised AXI4 memory master that replaces the separate single-beat read and write blocks with one unit. It accepts one request at a time from the core/LSU side and issues an INCR read burst (1..2^LEN_W beats) or a single-beat strobed write. It streams read beats back and reports completion and errors from RRESP/BRESP. The block contains no DPI; it drives the AXI slave model or interconnect directly.

Parameters:
ADDR_W, 32, request/AXI address width
DATA_W, 64, data width; strobe width is DATA_W/8
LEN_W, 4, req_len width; read burst length = req_len+1 beats

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  block idle, can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  start address
req_len  in  LEN_W  read beats minus 1; ignored for writes
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  write byte strobes
rd_valid  out  1  read beat valid, one-cycle pulse, no backpressure
rd_data  out  DATA_W  read beat data
rd_last  out  1  final beat of burst
done  out  1  one-cycle completion pulse
err  out  1  transaction error, meaningful only with done
ARVALID  out  1  AR valid
ARREADY  in  1  AR ready
ARADDR  out  ADDR_W  read address
ARLEN  out  8  burst length minus 1, zero-extended req_len
RVALID  in  1  R valid
RREADY  out  1  R ready
RDATA  in  DATA_W  read data
RRESP  in  2  read response
RLAST  in  1  slave last beat
AWVALID  out  1  AW valid
AWREADY  in  1  AW ready
AWADDR  out  ADDR_W  write address
WVALID  out  1  W valid
WREADY  in  1  W ready
WDATA  out  DATA_W  write data
WSTRB  out  DATA_W/8  write strobes
BVALID  in  1  B valid
BREADY  out  1  B ready
BRESP  in  2  write response

Behaviour:
- Reset: ARESETn is synchronous, active-low, sampled on ACLK. Reset forces state IDLE; all *VALID/*READY outputs, rd_valid, rd_last, done and err go to 0; req_ready goes to 1; address/data registers go to 0. A reset mid-transaction abandons the transaction; the next cycle shows reset values. The slave shares ARESETn.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr/len/wdata/wstrb and clear the beat counter and error accumulator. Then go to RD_ADDR if req_write=0, or WR_ADDR if req_write=1. req_ready=0 in every non-IDLE state.
- RD_ADDR: ARVALID=1; ARADDR/ARLEN stay stable until ARREADY, then go to RD_DATA. RREADY=0 in this state, so an RVALID arriving early is not accepted until RD_DATA.
- RD_DATA: RREADY=1. Each RVALID beat is registered: rd_data=RDATA and rd_valid=1 in the next cycle (latency 1). rd_last=1 on the beat where count==len; count increments per beat. RRESP!=0 on any beat sets the error accumulator. RLAST disagreeing with count==len also sets it. The burst always terminates on count==len, then returns to IDLE.
- WR_ADDR: AWVALID and WVALID are asserted together. Each deasserts independently after its own handshake; simultaneous handshakes are legal. When both have completed, go to WR_RESP. Writes are single-beat only (AWLEN=0 implied).
- WR_RESP: BREADY=1. On BVALID, BRESP!=0 sets the error accumulator; then return to IDLE.
- Completion: done=1 for exactly one cycle, coincident with the last rd_valid or the cycle after the B handshake. err=accumulator in that cycle, otherwise 0. req_ready=1 in the same cycle, so back-to-back requests are accepted without a bubble. Addresses are passed through unaligned and unmodified.

Test Plan:
- Single-beat read: req_addr=0x80000000, len=0; ARREADY 2 cycles late; RDATA=0x1122334455667788 with RLAST -> ARLEN=0; rd_valid pulses once with that data and rd_last=1; done=1, err=0 in the same cycle; req_ready=1.
- Burst read: len=3, RDATA 0xA0..0xA3 with 1-cycle RVALID gaps -> ARLEN=3; exactly 4 rd_valid pulses in order; rd_last only on 0xA3; single done; a second request issued on the done cycle is accepted.
- Write: addr=0x80000010, wdata=0xDEADBEEFCAFEF00D, wstrb=0x0F; AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake while WVALID holds; WSTRB=0x0F; done after BVALID with err=0. Repeat with BRESP=2 -> err=1 with done.
- Errors/reset: len=1 with RRESP=2 on beat 0 -> err=1 at done. Len=1 with RLAST on beat 0 -> 2 beats still consumed, err=1. ARESETn low during RD_DATA -> next cycle RREADY=0, req_ready=1, no done.
